bcd_countdown_timer: RTL
========================

// Module: bcd_countdown_timer
// PURPOSE
//  Loadable multi-digit BCD down-counter (countdown timer); complement of the decade up-counter.
//  Counts a loaded BCD value down to zero on qualified ticks, then flags expiry with a one-cycle done pulse.
//  Sits beside the decade counters in the timing blocks. It is driven by a prescaler strobe (tick_en)
//  and by control logic (load/start/stop).
// PARAMETERS
//  DIGITS  2  number of BCD digits; count range 0 .. 10^DIGITS-1
// PORTS
//  clk       in   1           rising-edge clock; single clock domain
//  rst_n     in   1           asynchronous, active-low reset
//  load      in   1           load load_val into count (sampled on clk)
//  load_val  in   4*DIGITS    BCD value to load; digit i = bits [4i+3:4i]
//  start     in   1           begin/resume countdown
//  stop      in   1           pause countdown; count held
//  tick_en   in   1           decrement strobe; acted on only in RUN
//  count     out  4*DIGITS    current BCD count (registered)
//  running   out  1           1 while state == RUN (registered)
//  zero      out  1           combinational: count == 0
//  done      out  1           one-cycle pulse when count reaches 0 from RUN (registered)
//  load_err  out  1           one-cycle pulse: load rejected, load_val held a digit > 9 (registered)
// BEHAVIOUR
//  Reset (rst_n=0, async, immediate, also mid-run)
//   - count=0, state=IDLE, running=0, done=0, load_err=0, zero=1.
//  States
//   - IDLE:    stopped or paused.
//   - RUN:     counting.
//   - EXPIRED: reached 0; holds until the next valid load.
//  Per-edge priority: load > stop > start > tick_en.
//  load (any state)
//   - All digits <= 9: count<=load_val, state<=IDLE, running<=0.
//   - Any digit > 9: count and state unchanged, load_err=1 for 1 cycle.
//   - start/stop/tick_en in the same cycle are ignored.
//  stop
//   - RUN -> IDLE; no decrement that cycle even if tick_en=1.
//   - In other states: no effect.
//  start
//   - IDLE with count!=0 -> RUN; running=1 after that edge.
//   - IDLE with count==0, RUN, or EXPIRED: ignored.
//   - start+stop in the same cycle: stop wins (stays or goes IDLE).
//  tick_en in RUN
//   - BCD decrement: digit 0 -> 9 and borrows from the next digit; all others -1.
//   - Earliest decrement is on the first edge after the one that entered RUN.
//  Expiry
//   - Decrementing from 1 makes count=0 and, on the same edge: state<=EXPIRED, running<=0, done<=1.
//   - done stays high exactly one cycle and is never asserted by load or reset.
//  tick_en outside RUN is ignored; count never wraps below 0.
//  Only legal BCD appears on count.
//  Loading 0 goes to IDLE with zero=1; a subsequent start is ignored.
// TESTING  (DIGITS=2 unless stated)
//  1 rst_n=0 mid-cycle during RUN -> count=8'h00, running=0, done=0, zero=1 before next clk edge.
//  2 load 8'h12, start, tick_en=1 every cycle -> count 12,11,10,09..01,00; done=1 for the single
//    cycle count=00, running=0; further ticks hold 00.
//  3 load 8'h10, start, one tick -> 8'h09 (borrow). DIGITS=3: load 12'h100, one tick -> 12'h099.
//  4 load 8'h1A -> load_err pulse 1 cycle, count and state unchanged; load 8'h99 -> no load_err, count=99.
//  5 load 8'h05, start, 2 ticks -> 03; stop+tick_en same cycle -> 03 held, running=0;
//    start -> running=1, next tick -> 02.
//  6 load 8'h00 then start -> running stays 0, done stays 0.
//    After expiry (EXPIRED): start ignored; load 8'h03 -> IDLE, count=03.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD countdown timer: counts a loaded value down to zero on
// qualified ticks, then pulses done for one cycle and holds in EXPIRED until reloaded.
module bcd_countdown_timer #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick_en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  zero,
  output logic                  done,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_count;
  logic [W-1:0]   w_count_nxt;
  logic [W-1:0]   w_count_dec;
  logic           r_done;
  logic           w_done_nxt;
  logic           r_load_err;
  logic           w_load_err_nxt;
  logic           w_load_ok;
  logic           w_count_one;

  always_comb begin : load_check
    w_load_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) w_load_ok = 1'b0;
    end
  end

  // Ripple borrow: trailing zero digits become 9 until the first nonzero digit is decremented.
  always_comb begin : bcd_decrement
    logic v_borrow;
    v_borrow    = 1'b1;
    w_count_dec = r_count;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v_borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_count_dec[4*i +: 4] = 4'd9;
        end else begin
          w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          v_borrow = 1'b0;
        end
      end
    end
  end

  assign w_count_one = (r_count == W'(1));

  always_comb begin : next_state
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_done_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        w_count_nxt = load_val;
        w_state_nxt = IDLE;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (stop) begin
      if (r_state == RUN) w_state_nxt = IDLE;
    end else if (start) begin
      if (r_state == IDLE && r_count != '0) w_state_nxt = RUN;
    end else if (tick_en && r_state == RUN && r_count != '0) begin
      w_count_nxt = w_count_dec;
      if (w_count_one) begin
        w_state_nxt = EXPIRED;
        w_done_nxt  = 1'b1;
      end
    end
    if (r_state != IDLE && r_state != RUN && r_state != EXPIRED) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_done     <= w_done_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign count    = r_count;
  assign running  = (r_state == RUN);
  assign zero     = (r_count == '0);
  assign done     = r_done;
  assign load_err = r_load_err;

endmodule
